// File: rtl/uart_telemetry_tx.sv
// rtl/uart_telemetry_tx.sv - periodic/manual multi-channel telemetry packet UART transmitter
// Packet: HEADER, channel bytes (ch0 first, MSB first), XOR checksum of channel bytes.
module uart_telemetry_tx #(
  parameter int         NUM_CH       = 2,
  parameter int         DATA_W       = 16,
  parameter int         CLKS_PER_BIT = 1250,
  parameter int         STOP_BITS    = 2,
  parameter int         PERIOD_CLKS  = 12000000,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     send_now,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     tx,
  output logic                     busy,
  output logic                     pkt_done,
  output logic                     overrun
);
  localparam int BPC    = DATA_W / 8;
  localparam int NDB    = NUM_CH * BPC;
  localparam int NB     = NDB + 2;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PER_W  = $clog2(PERIOD_CLKS);
  localparam int BYTE_W = $clog2(NB);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CLKS - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NB - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        clk_cnt, clk_cnt_n;
  logic [2:0]              bit_idx, bit_idx_n;
  logic [BYTE_W-1:0]       byte_idx, byte_idx_n;
  logic [PER_W-1:0]        period_cnt;
  logic [NUM_CH*DATA_W-1:0] snapshot;
  logic [7:0]              data_bytes [NDB];
  logic [7:0]              cur_byte;
  logic [7:0]              csum;
  logic                    periodic, trigger, accept, bit_end;

  assign periodic = ena && (period_cnt == PER_LAST);
  assign trigger  = ena && (periodic || send_now);
  assign busy     = (state != S_IDLE);
  assign accept   = trigger && !busy;
  assign overrun  = trigger && busy;
  assign bit_end  = (clk_cnt == BIT_LAST);

  // Runs regardless of busy so the trigger cadence is not stretched by packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              period_cnt <= '0;
    else if (!ena || period_cnt == PER_LAST) period_cnt <= '0;
    else                                     period_cnt <= period_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      snapshot <= '0;
    else if (accept) snapshot <= ch_data;
  end

  for (genvar g = 0; g < NDB; g++) begin : g_bytes
    assign data_bytes[g] = snapshot[(g / BPC) * DATA_W + (BPC - 1 - g % BPC) * 8 +: 8];
  end

  // byte_idx 0 is the header, 1..NDB the channel bytes, NB-1 the checksum.
  always_comb begin
    csum     = '0;
    cur_byte = HEADER;
    for (int i = 0; i < NDB; i++) begin
      csum = csum ^ data_bytes[i];
      if (byte_idx == BYTE_W'(i + 1)) cur_byte = data_bytes[i];
    end
    if (byte_idx == BYTE_LAST) cur_byte = csum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    pkt_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n    = S_START;
          clk_cnt_n  = '0;
          bit_idx_n  = '0;
          byte_idx_n = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = S_STOP;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            if (byte_idx == BYTE_LAST) begin
              pkt_done = 1'b1;
              state_n  = S_IDLE;
            end else begin
              byte_idx_n = byte_idx + 1'b1;
              state_n    = S_START;
            end
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_telemetry_tx.sv
// tb/tb_uart_telemetry_tx.sv - self-checking bench for uart_telemetry_tx
// A UART line decoder and event monitors feed a packet-level reference model.
module tb_uart_telemetry_tx;
  localparam int CPB    = 4;
  localparam int STOP   = 2;
  localparam int PERIOD = 400;
  localparam int PKT_LEN = 6 * (9 + STOP) * CPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        send_now;
  logic [31:0] ch_data;
  logic        tx, busy, pkt_done, overrun;

  uart_telemetry_tx #(
    .NUM_CH(2), .DATA_W(16), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP),
    .PERIOD_CLKS(PERIOD), .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .send_now(send_now), .ch_data(ch_data),
    .tx(tx), .busy(busy), .pkt_done(pkt_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  rx_q[$];
  int unsigned rx_start_q[$];
  int unsigned busy_start_q[$];
  int unsigned busy_len_q[$];
  logic [7:0]  exp_q[$];
  int          done_cnt = 0, ovr_cnt = 0, low_cnt = 0, frame_err = 0;
  int unsigned busy_run = 0;
  logic        busy_d = 1'b0;
  logic [7:0]  dec_b;
  int unsigned dec_sc;

  always @(negedge clk) begin
    if (busy && !busy_d) busy_start_q.push_back(cyc);
    if (busy) busy_run++;
    if (!busy && busy_d) begin
      busy_len_q.push_back(busy_run);
      busy_run = 0;
    end
    busy_d = busy;
    if (pkt_done) done_cnt++;
    if (overrun) ovr_cnt++;
    if (tx === 1'b0) low_cnt++;
  end

  // Mid-bit sampling UART receiver.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        dec_sc = cyc;
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) frame_err++;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          dec_b[k] = tx;
        end
        for (int k = 0; k < STOP; k++) begin
          repeat (CPB) @(negedge clk);
          if (tx !== 1'b1) frame_err++;
        end
        rx_q.push_back(dec_b);
        rx_start_q.push_back(dec_sc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete(); rx_start_q.delete(); busy_start_q.delete(); busy_len_q.delete();
    done_cnt = 0; ovr_cnt = 0; low_cnt = 0; frame_err = 0;
  endtask

  // Expected packet: header, ch0 hi/lo, ch1 hi/lo, XOR of the four data bytes.
  function automatic void build_exp(input logic [31:0] d);
    logic [7:0] cs;
    logic [7:0] bv;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int ch = 0; ch < 2; ch++) begin
      for (int j = 0; j < 2; j++) begin
        bv = 8'((d >> (ch * 16 + 8 * (1 - j))) & 32'hFF);
        exp_q.push_back(bv);
        cs = cs ^ bv;
      end
    end
    exp_q.push_back(cs);
  endfunction

  task automatic send_pulse(output int unsigned acc);
    @(posedge clk); #1;
    ena = 1'b1; send_now = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0; send_now = 1'b0;
    acc = cyc;
  endtask

  task automatic check_packet(input string tag, input logic [31:0] d,
                              input int unsigned acc, input int exp_ovr);
    build_exp(d);
    check({tag, "_nbytes"}, rx_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < rx_q.size()) check({tag, "_byte"}, {i[7:0], rx_q[i]}, {i[7:0], exp_q[i]});
    check({tag, "_npkt"}, busy_start_q.size(), 1);
    if (busy_start_q.size() > 0) check({tag, "_busy_start"}, busy_start_q[0], acc);
    if (rx_start_q.size() > 0) check({tag, "_tx_start"}, rx_start_q[0], acc);
    if (busy_len_q.size() > 0) check({tag, "_busy_len"}, busy_len_q[0], PKT_LEN);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_ovr"}, ovr_cnt, exp_ovr);
    check({tag, "_frame"}, frame_err, 0);
  endtask

  int unsigned acc, acc2, c0;
  logic [31:0] rd;

  initial begin
    rst_n = 1'b0; ena = 1'b0; send_now = 1'b0; ch_data = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_tx", tx, 1); check("rst_busy", busy, 0);
    check("rst_done", pkt_done, 0); check("rst_ovr", overrun, 0);

    // Periodic triggers from reset, ena dropped while the second packet is in flight.
    ch_data = 32'h0102_0304;
    rst_n = 1'b1; ena = 1'b1;
    c0 = cyc;
    clear_mon();
    repeat (900) @(posedge clk); #1;
    ena = 1'b0;
    check("per_done_900", done_cnt, 1);
    repeat (200) @(posedge clk); #1;
    check("per_npkt", busy_start_q.size(), 2);
    if (busy_start_q.size() > 1) begin
      check("per_start0", busy_start_q[0], c0 + PERIOD);
      check("per_start1", busy_start_q[1], c0 + 2 * PERIOD);
    end
    if (busy_len_q.size() > 1) check("per_len_ena_drop", busy_len_q[1], PKT_LEN);
    check("per_done", done_cnt, 2);
    check("per_nbytes", rx_q.size(), 12);

    // Fixed vector, then snapshot isolation from later ch_data changes.
    ch_data = 32'hCDAB_3412;
    clear_mon();
    send_pulse(acc);
    repeat (300) @(posedge clk); #1;
    check_packet("fixed", 32'hCDAB_3412, acc, 0);
    check("fixed_idle", busy, 0);

    clear_mon();
    send_pulse(acc);
    ch_data = 32'h0;
    repeat (300) @(posedge clk); #1;
    check_packet("snap", 32'hCDAB_3412, acc, 0);

    for (int n = 0; n < 5; n++) begin
      rd = $urandom;
      ch_data = rd;
      clear_mon();
      repeat ($urandom_range(0, 20)) @(posedge clk);
      send_pulse(acc);
      ch_data = $urandom;
      repeat (300) @(posedge clk); #1;
      check_packet("rand", rd, acc, 0);
    end

    // Trigger during a packet is dropped with a single overrun pulse.
    ch_data = 32'h5A5A_C3E1;
    clear_mon();
    send_pulse(acc);
    repeat (98) @(posedge clk);
    send_pulse(acc2);
    repeat (300) @(posedge clk); #1;
    check_packet("ovr", 32'h5A5A_C3E1, acc, 1);

    // Asynchronous reset mid-packet.
    clear_mon();
    send_pulse(acc);
    repeat (49) @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", busy, 0);
    repeat (3) @(posedge clk); #1;
    check("arst_done", done_cnt, 0);
    rst_n = 1'b1;
    repeat (60) @(posedge clk); #1;
    clear_mon();
    repeat (300) @(posedge clk); #1;
    check("arst_quiet_low", low_cnt, 0);
    check("arst_quiet_pkt", busy_start_q.size(), 0);
    clear_mon();
    ch_data = 32'h1111_2222;
    send_pulse(acc);
    repeat (300) @(posedge clk); #1;
    check_packet("post_rst", 32'h1111_2222, acc, 0);

    // ena=0 blocks send_now and holds the period counter at 0.
    clear_mon();
    @(posedge clk); #1;
    send_now = 1'b1;
    @(posedge clk); #1;
    send_now = 1'b0;
    repeat (200) @(posedge clk); #1;
    check("dis_low", low_cnt, 0);
    check("dis_pkt", busy_start_q.size(), 0);
    check("dis_ovr", ovr_cnt, 0);
    ena = 1'b1;
    c0 = cyc;
    repeat (410) @(posedge clk); #1;
    ena = 1'b0;
    repeat (300) @(posedge clk); #1;
    check("dis_npkt", busy_start_q.size(), 1);
    if (busy_start_q.size() > 0) check("dis_first_period", busy_start_q[0], c0 + PERIOD);
    check("dis_done", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
